// File: rtl/acc_cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Optional SINGLE_STEP_EN adds iSTEP and a STEP_WAIT state between instructions.
module acc_cpu_sequencer #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              iCLK,
    input  logic              iRST_N,
`ifdef SINGLE_STEP_EN
    input  logic              iSTEP,
`endif
    output logic              oMEM_REQ,
    output logic              oMEM_WE,
    output logic [ADDR_W-1:0] oMEM_ADDR,
    output logic [DATA_W-1:0] oMEM_WDATA,
    input  logic              iMEM_ACK,
    input  logic [DATA_W-1:0] iMEM_RDATA,
    output logic [3:0]        oALU_OP,
    output logic [DATA_W-1:0] oALU_IN1,
    output logic [DATA_W-1:0] oALU_IN2,
    input  logic [DATA_W-1:0] iALU_Z,
    output logic [ADDR_W-1:0] oPC,
    output logic [DATA_W-1:0] oACC,
    output logic              oHALT
);

`ifdef SINGLE_STEP_EN
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_READ, S_EXEC, S_WRITE, S_HALT, S_STEP
    } state_t;
    localparam state_t S_NEXT = S_STEP;
`else
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_READ, S_EXEC, S_WRITE, S_HALT
    } state_t;
    localparam state_t S_NEXT = S_FETCH;
`endif

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  mdr_q, mdr_d;

    logic               req, we, halt;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [3:0]         alu_op;
    logic [3:0]         opcode;
    logic [ADDR_W-1:0]  iaddr;

    assign opcode = ir_q[DATA_W-1:DATA_W-4];
    assign iaddr  = ir_q[ADDR_W-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        mdr_d   = mdr_q;
        req     = 1'b0;
        we      = 1'b0;
        halt    = 1'b0;
        addr    = pc_q;
        wdata   = '0;
        alu_op  = 4'hF;
        unique case (state_q)
            S_FETCH: begin
                req = 1'b1;
                if (iMEM_ACK) begin
                    ir_d    = iMEM_RDATA;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    4'h0, 4'h1, 4'h2, 4'h3: state_d = S_EXEC;
                    4'h4, 4'h6:             state_d = S_READ;
                    4'h5:                   state_d = S_WRITE;
                    4'h7: begin
                        pc_d    = iaddr;
                        state_d = S_NEXT;
                    end
                    4'hF:                   state_d = S_HALT;
                    default:                state_d = S_NEXT;
                endcase
            end
            S_READ: begin
                req  = 1'b1;
                addr = iaddr;
                if (iMEM_ACK) begin
                    mdr_d   = iMEM_RDATA;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op  = opcode;
                acc_d   = iALU_Z;
                state_d = S_NEXT;
            end
            S_WRITE: begin
                req    = 1'b1;
                we     = 1'b1;
                addr   = iaddr;
                alu_op = 4'h5;
                wdata  = iALU_Z;
                if (iMEM_ACK) state_d = S_NEXT;
            end
            S_HALT: halt = 1'b1;
`ifdef SINGLE_STEP_EN
            S_STEP: if (iSTEP) state_d = S_FETCH;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RST;
            ir_q    <= '0;
            acc_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            mdr_q   <= mdr_d;
        end
    end

    // Reset masks the bus so a held reset never presents a request.
    assign oMEM_REQ   = req & iRST_N;
    assign oMEM_WE    = we & iRST_N;
    assign oMEM_ADDR  = addr;
    assign oMEM_WDATA = iRST_N ? wdata : '0;
    assign oALU_OP    = iRST_N ? alu_op : 4'hF;
    assign oALU_IN1   = acc_q;
    assign oALU_IN2   = mdr_q;
    assign oPC        = pc_q;
    assign oACC       = acc_q;
    assign oHALT      = halt & iRST_N;

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Scoreboard bench for acc_cpu_sequencer with a behavioural memory and ALU.
module tb_acc_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req, we, halt;
    logic [3:0] addr, pc, alu_op;
    logic [7:0] wdata, rdata, in1, in2, alu_z, acc;
    logic       ack;
`ifdef SINGLE_STEP_EN
    logic       step = 1'b1;
`endif

    logic [7:0] mem [16];
    logic [7:0] img [16];
    logic       load_en = 1'b0;
    logic [3:0] load_a = '0;
    int         wait_n = 0;
    int         cnt = 0;
    logic       hold_ack = 1'b0;
    logic       ack_force = 1'b0;

    int n_pass = 0;
    int n_total = 0;
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    acc_cpu_sequencer dut (
        .iCLK(clk),
        .iRST_N(rst_n),
`ifdef SINGLE_STEP_EN
        .iSTEP(step),
`endif
        .oMEM_REQ(req),
        .oMEM_WE(we),
        .oMEM_ADDR(addr),
        .oMEM_WDATA(wdata),
        .iMEM_ACK(ack),
        .iMEM_RDATA(rdata),
        .oALU_OP(alu_op),
        .oALU_IN1(in1),
        .oALU_IN2(in2),
        .iALU_Z(alu_z),
        .oPC(pc),
        .oACC(acc),
        .oHALT(halt)
    );

    assign ack = ack_force | (req & (cnt >= wait_n) & ~hold_ack);
    assign rdata = mem[addr];

    always_comb begin
        case (alu_op)
            4'h0: alu_z = 8'h00;
            4'h1: alu_z = ~in1;
            4'h2: alu_z = {in1[7], in1[7:1]};
            4'h3: alu_z = {in1[6:0], in1[7]};
            4'h4: alu_z = in1 + in2;
            4'h6: alu_z = in2;
            default: alu_z = in1;
        endcase
    end

    always @(posedge clk) begin
        if (load_en) mem[load_a] <= img[load_a];
        else if (req & we & ack) mem[addr] <= wdata;
        if (req & ~ack) cnt <= cnt + 1;
        else cnt <= 0;
    end

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: checks bus stability and pops expected writes.
    initial begin
        logic       open_p;
        logic [3:0] a_p;
        logic       we_p;
        logic [7:0] wd_p;
        logic [11:0] e;
        open_p = 1'b0;
        a_p = '0;
        we_p = 1'b0;
        wd_p = '0;
        forever begin
            @(negedge clk);
            #3;
            if (open_p && req) begin
                check("stable_addr", {12'h0, addr}, {12'h0, a_p});
                check("stable_we", {15'h0, we}, {15'h0, we_p});
                check("stable_wdata", {8'h0, wdata}, {8'h0, wd_p});
            end
            if (req && we && ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {4'h0, addr, wdata}, 16'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {4'h0, addr, wdata}, {4'h0, e});
                end
            end
            open_p = req & ~ack;
            a_p = addr;
            we_p = we;
            wd_p = wdata;
        end
    end

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) img[i] = v;
    endtask

    task automatic load_and_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            load_en = 1'b1;
            load_a = 4'(i);
            @(negedge clk);
        end
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (!halt && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!halt) check("halt_timeout", 16'h0, 16'h1);
    endtask

    task automatic add_sum_prog(input int ws, input bit exact);
        int cyc;
        fill(8'h80);
        img[0] = 8'h68;
        img[1] = 8'h49;
        img[2] = 8'h5A;
        img[3] = 8'hF0;
        img[8] = 8'h05;
        img[9] = 8'h0C;
        wait_n = ws;
        exp_q.push_back({4'hA, 8'h11});
        load_and_reset();
        run_to_halt(cyc);
        if (exact) check("zero_wait_cycles", 16'(cyc), 16'd13);
        check("sum_acc", {8'h0, acc}, 16'h0011);
        check("sum_halt", {15'h0, halt}, 16'h1);
        check("sum_mem", {8'h0, mem[10]}, 16'h0011);
        check("sum_pc", {12'h0, pc}, 16'h0004);
        check("sum_q_empty", 16'(exp_q.size()), 16'h0);
    endtask

    initial begin
        int cyc;
        // Reset with ACK stuck high.
        rst_n = 1'b0;
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req", {15'h0, req}, 16'h0);
        check("rst_pc", {12'h0, pc}, 16'h0);
        check("rst_acc", {8'h0, acc}, 16'h0);
        check("rst_halt", {15'h0, halt}, 16'h0);
        check("rst_aluop", {12'h0, alu_op}, 16'hF);
        ack_force = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_req", {15'h0, req}, 16'h1);
        check("rel_addr", {12'h0, addr}, 16'h0);

        add_sum_prog(0, 1'b1);
        add_sum_prog(3, 1'b0);

        // Unary ops on ACC=81.
        fill(8'h80);
        img[0] = 8'h6F;
        img[1] = 8'h30;
        img[2] = 8'h5A;
        img[3] = 8'h10;
        img[4] = 8'h5B;
        img[5] = 8'h20;
        img[6] = 8'h5C;
        img[7] = 8'h00;
        img[8] = 8'h5D;
        img[9] = 8'hF0;
        img[15] = 8'h81;
        wait_n = 0;
        exp_q.push_back({4'hA, 8'h03});
        exp_q.push_back({4'hB, 8'hFC});
        exp_q.push_back({4'hC, 8'hFE});
        exp_q.push_back({4'hD, 8'h00});
        load_and_reset();
        run_to_halt(cyc);
        check("unary_acc", {8'h0, acc}, 16'h0);
        check("unary_q_empty", 16'(exp_q.size()), 16'h0);

        // JMP to F, then JMP 3 from F.
        fill(8'h80);
        img[0] = 8'h7F;
        img[15] = 8'h73;
        img[3] = 8'hF0;
        load_and_reset();
        repeat (2) @(negedge clk);
        check("jmp_f_addr", {12'h0, addr}, 16'hF);
        repeat (2) @(negedge clk);
        check("jmp_3_addr", {12'h0, addr}, 16'h3);
        check("jmp_3_req", {15'h0, req}, 16'h1);
        run_to_halt(cyc);
        check("jmp_pc", {12'h0, pc}, 16'h4);

        // NOP at F wraps PC to 0.
        img[15] = 8'h80;
        load_and_reset();
        repeat (4) @(negedge clk);
        check("nop_wrap_addr", {12'h0, addr}, 16'h0);
        check("nop_wrap_pc", {12'h0, pc}, 16'h0);

        // Reset while READ is pending, ACK arrives under reset.
        fill(8'h80);
        img[0] = 8'h68;
        img[8] = 8'h55;
        load_and_reset();
        @(negedge clk);
        hold_ack = 1'b1;
        @(negedge clk);
        check("read_req", {15'h0, req}, 16'h1);
        check("read_addr", {12'h0, addr}, 16'h8);
        @(negedge clk);
        rst_n = 1'b0;
        ack_force = 1'b1;
        hold_ack = 1'b0;
        @(negedge clk);
        check("rr_mdr", {8'h0, in2}, 16'h0);
        check("rr_acc", {8'h0, acc}, 16'h0);
        check("rr_pc", {12'h0, pc}, 16'h0);
        check("rr_req", {15'h0, req}, 16'h0);
        ack_force = 1'b0;

`ifdef SINGLE_STEP_EN
        fill(8'h80);
        step = 1'b0;
        load_and_reset();
        repeat (5) @(negedge clk);
        check("step_wait_req", {15'h0, req}, 16'h0);
        check("step_wait_pc", {12'h0, pc}, 16'h1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (5) @(negedge clk);
        check("step_one_pc", {12'h0, pc}, 16'h2);
        check("step_one_req", {15'h0, req}, 16'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
